// File: rtl/tnew_scoreboard_if.sv
// Decoder-to-scoreboard bundle: D-stage operand/result info toward the scoreboard,
// stall / forwarding select / md busy back toward the pipeline control.
interface tnew_scoreboard_if #(
    parameter int STAGES = 3,
    parameter int SW     = $clog2(STAGES + 1)
) ();
    logic [1:0]    tuse_rs;
    logic [1:0]    tuse_rt;
    logic [2:0]    res_d;
    logic [4:0]    rs_d;
    logic [4:0]    rt_d;
    logic [4:0]    wa_d;
    logic          md_start_d;
    logic          md_div_d;
    logic          md_use_d;
    logic          flush;
    logic          stall;
    logic [SW-1:0] fwd_rs_sel;
    logic [SW-1:0] fwd_rt_sel;
    logic          md_busy;

    modport master (
        output tuse_rs, tuse_rt, res_d, rs_d, rt_d, wa_d,
        output md_start_d, md_div_d, md_use_d, flush,
        input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    modport slave (
        input  tuse_rs, tuse_rt, res_d, rs_d, rt_d, wa_d,
        input  md_start_d, md_div_d, md_use_d, flush,
        output stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );
endinterface

// File: rtl/tnew_scoreboard.sv
// Tuse/Tnew hazard scoreboard for the D stage: tracks in-flight producers, raises stall,
// selects forwarding stage. Optional mult/div busy counter under `define MD_UNIT_EN.
module tnew_scoreboard #(
    parameter int STAGES      = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int SW          = $clog2(STAGES + 1)
) (
    input logic              clk,
    input logic              reset,
    tnew_scoreboard_if.slave bus
);
    localparam logic [2:0] RES_NW    = 3'd0;
    localparam logic [2:0] RES_ALU   = 3'd1;
    localparam logic [2:0] RES_DM    = 3'd2;
    localparam logic [2:0] RES_PC    = 3'd3;
    localparam logic [2:0] RES_OTHER = 3'd4;

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;

    logic [STAGES:1] valid_q, valid_d;
    logic [4:0]      addr_q [1:STAGES];
    logic [4:0]      addr_d [1:STAGES];
    logic [1:0]      tnew_q [1:STAGES];
    logic [1:0]      tnew_d [1:STAGES];

    logic          insValid;
    logic [1:0]    insTnew;
    logic          rsHit, rtHit;
    logic [SW-1:0] rsSel, rtSel;
    logic [1:0]    rsTnew, rtTnew;
    logic          rsStall, rtStall;
    logic          mdBusy, mdStall;
    logic          stallAll;

    always_comb begin
        insValid = 1'b0;
        insTnew  = 2'd0;
        case (bus.res_d)
            RES_NW:    insValid = 1'b0;
            RES_ALU:   begin insValid = 1'b1; insTnew = 2'd1; end
            RES_DM:    begin insValid = 1'b1; insTnew = 2'd2; end
            RES_PC:    insValid = 1'b1;
            RES_OTHER: insValid = 1'b1;
            default:   insValid = 1'b0;
        endcase
        if (bus.wa_d == 5'd0) insValid = 1'b0;
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        rsHit  = 1'b0;
        rsSel  = '0;
        rsTnew = 2'd0;
        rtHit  = 1'b0;
        rtSel  = '0;
        rtTnew = 2'd0;
        for (int k = STAGES; k >= 1; k--) begin
            if (valid_q[k] && (addr_q[k] == bus.rs_d) && (bus.rs_d != 5'd0)) begin
                rsHit  = 1'b1;
                rsSel  = SW'(k);
                rsTnew = tnew_q[k];
            end
            if (valid_q[k] && (addr_q[k] == bus.rt_d) && (bus.rt_d != 5'd0)) begin
                rtHit  = 1'b1;
                rtSel  = SW'(k);
                rtTnew = tnew_q[k];
            end
        end
    end

    assign rsStall  = rsHit && (bus.tuse_rs != 2'd3) && (rsTnew > bus.tuse_rs);
    assign rtStall  = rtHit && (bus.tuse_rt != 2'd3) && (rtTnew > bus.tuse_rt);
    assign stallAll = rsStall || rtStall || mdStall;

    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            valid_d[k] = 1'b0;
            addr_d[k]  = 5'd0;
            tnew_d[k]  = 2'd0;
        end
        for (int k = STAGES; k >= 2; k--) begin
            valid_d[k] = valid_q[k-1] && !bus.flush;
            addr_d[k]  = addr_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] == 2'd0) ? 2'd0 : tnew_q[k-1] - 2'd1;
        end
        valid_d[1] = insValid && !stallAll && !bus.flush;
        addr_d[1]  = bus.wa_d;
        tnew_d[1]  = insTnew;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                addr_q[k] <= 5'd0;
                tnew_q[k] <= 2'd0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 1; k <= STAGES; k++) begin
                addr_q[k] <= addr_d[k];
                tnew_q[k] <= tnew_d[k];
            end
        end
    end

`ifdef MD_UNIT_EN
    localparam int CW = $clog2(MD_MAX + 1);

    logic [CW-1:0] md_cnt_q, md_cnt_d;

    assign mdBusy  = (md_cnt_q != '0);
    assign mdStall = (bus.md_start_d || bus.md_use_d) && mdBusy;

    // Counter keeps running through stalls and flushes; only a start that really enters E reloads it.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (bus.md_start_d && !stallAll && !bus.flush)
            md_cnt_d = bus.md_div_d ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) md_cnt_q <= '0;
        else       md_cnt_q <= md_cnt_d;
    end
`else
    logic unused_md;
    assign unused_md = ^{bus.md_start_d, bus.md_div_d, bus.md_use_d, 1'(MD_MAX)};
    assign mdBusy    = 1'b0;
    assign mdStall   = 1'b0;
`endif

    assign bus.stall      = stallAll;
    assign bus.fwd_rs_sel = rsSel;
    assign bus.fwd_rt_sel = rtSel;
    assign bus.md_busy    = mdBusy;
endmodule
